// File: rtl/wbuf_load_seq_if.sv
// Weight-buffer load bus: job control, weight-word stream and decoder write-select side.
interface wbuf_load_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              START;
  logic              BCAST;
  logic [4:0]        FIRST_BUF;
  logic [5:0]        NUM_BUF;
  logic [ADDR_W:0]   WORDS;
  logic [DATA_W-1:0] S_DATA;
  logic              S_VALID;
  logic              S_READY;
  logic [4:0]        D_IN;
  logic              D_EN;
  logic              WBUF_ALL_EN;
  logic [ADDR_W-1:0] WBUF_ADDR;
  logic [DATA_W-1:0] WBUF_DATA;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  START, BCAST, FIRST_BUF, NUM_BUF, WORDS, S_DATA, S_VALID,
    output S_READY, D_IN, D_EN, WBUF_ALL_EN, WBUF_ADDR, WBUF_DATA, BUSY, DONE
  );

  modport slave (
    output START, BCAST, FIRST_BUF, NUM_BUF, WORDS, S_DATA, S_VALID,
    input  S_READY, D_IN, D_EN, WBUF_ALL_EN, WBUF_ADDR, WBUF_DATA, BUSY, DONE
  );
endinterface

// File: rtl/wbuf_load_seq.sv
// Weight-buffer load sequencer: turns a weight-word stream into one registered write strobe
// per accepted word, filling a buffer range word-major or broadcasting to all 32 buffers.
module wbuf_load_seq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic          CLK,
  input  logic          RST,
  wbuf_load_seq_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [5:0]      LP_NBUF  = 6'd32;

  state_t            r_state, w_next;
  logic              r_bcast;
  logic [5:0]        r_num_buf;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [5:0]        r_buf_cnt;
  logic [4:0]        r_buf_idx;

  logic              r_d_en, r_all_en;
  logic [4:0]        r_d_in;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic [5:0]        w_num_clamp;
  logic [ADDR_W:0]   w_words_clamp;
  logic              w_zero, w_start, w_acc, w_word_last, w_buf_last, w_last;

  assign w_num_clamp   = (bus.NUM_BUF > LP_NBUF) ? LP_NBUF : bus.NUM_BUF;
  assign w_words_clamp = (bus.WORDS > LP_DEPTH) ? LP_DEPTH : bus.WORDS;
  assign w_zero        = (w_words_clamp == '0) || (!bus.BCAST && (w_num_clamp == '0));
  assign w_start       = (r_state == S_IDLE) && bus.START;
  assign w_acc         = (r_state == S_LOAD) && bus.S_VALID;
  // r_words is at least 1 whenever LOAD is reachable, so the decrement never underflows
  assign w_word_last   = ({1'b0, r_word_cnt} == (r_words - 1'b1));
  assign w_buf_last    = r_bcast || (r_buf_cnt == (r_num_buf - 6'd1));
  assign w_last        = w_acc && w_word_last && w_buf_last;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.START) w_next = w_zero ? S_DONE : S_LOAD;
      S_LOAD:  if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.S_READY = (r_state == S_LOAD);
    bus.BUSY    = (r_state != S_IDLE);
    bus.DONE    = (r_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bcast    <= 1'b0;
      r_num_buf  <= '0;
      r_words    <= '0;
      r_word_cnt <= '0;
      r_buf_cnt  <= '0;
      r_buf_idx  <= '0;
      r_d_en     <= 1'b0;
      r_all_en   <= 1'b0;
      r_d_in     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_d_en   <= w_acc && !r_bcast;
      r_all_en <= w_acc && r_bcast;
      if (w_start) begin
        r_bcast    <= bus.BCAST;
        r_num_buf  <= w_num_clamp;
        r_words    <= w_words_clamp;
        r_word_cnt <= '0;
        r_buf_cnt  <= '0;
        r_buf_idx  <= bus.FIRST_BUF;
      end
      if (w_acc) begin
        r_d_in <= r_bcast ? 5'd0 : r_buf_idx;
        r_addr <= r_word_cnt;
        r_data <= bus.S_DATA;
        // buffer index is 5-bit and wraps 31 -> 0 naturally
        if (w_word_last) begin
          r_word_cnt <= '0;
          r_buf_cnt  <= r_buf_cnt + 6'd1;
          r_buf_idx  <= r_buf_idx + 5'd1;
        end else begin
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.D_EN        = r_d_en;
  assign bus.WBUF_ALL_EN = r_all_en;
  assign bus.D_IN        = r_d_in;
  assign bus.WBUF_ADDR   = r_addr;
  assign bus.WBUF_DATA   = r_data;

endmodule

// File: tb/tb_wbuf_load_seq.sv
// Directed bench for wbuf_load_seq: strobe order, wrap, broadcast, gaps, clamps, reset mid-job.
module tb_wbuf_load_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  wbuf_load_seq_if #(.DATA_W(32), .ADDR_W(6)) bus ();

  wbuf_load_seq #(.DATA_W(32), .DEPTH(64), .ADDR_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int q_din[$], q_addr[$], q_data[$], q_all[$], q_cyc[$], acc_q[$];
  int both_cnt = 0, done_cnt = 0, rdy_seen = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.D_EN || bus.WBUF_ALL_EN) begin
      q_din.push_back(int'(bus.D_IN));
      q_addr.push_back(int'(bus.WBUF_ADDR));
      q_data.push_back(int'(bus.WBUF_DATA));
      q_all.push_back(int'(bus.WBUF_ALL_EN));
      q_cyc.push_back(cyc);
    end
    if (bus.D_EN && bus.WBUF_ALL_EN) both_cnt++;
    if (bus.DONE) done_cnt++;
    if (bus.S_READY) rdy_seen = 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_din.delete(); q_addr.delete(); q_data.delete(); q_all.delete();
    q_cyc.delete(); acc_q.delete();
    both_cnt = 0; done_cnt = 0; rdy_seen = 0;
  endtask

  task automatic start_job(input logic bc, input logic [4:0] fb, input logic [5:0] nb,
                           input logic [6:0] wd);
    bus.BCAST = bc; bus.FIRST_BUF = fb; bus.NUM_BUF = nb; bus.WORDS = wd;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  // Bit c of vpat is S_VALID in cycle c; beyond plen S_VALID stays high.
  task automatic feed(input int n, input int base, input logic [15:0] vpat, input int plen);
    int k = 0;
    int c = 0;
    logic acc;
    while (k < n && c < 400) begin
      bus.S_VALID = (c < plen) ? vpat[c] : 1'b1;
      bus.S_DATA  = 32'(base + k);
      acc = bus.S_VALID && bus.S_READY;
      if (acc) acc_q.push_back(cyc + 1);
      tick();
      if (acc) k++;
      c++;
    end
    bus.S_VALID = 1'b0;
    chk("feed_beats", 64'(k), 64'(n));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (bus.BUSY && c < 20) begin
      tick();
      c++;
    end
    chk("idle_timeout", 64'(bus.BUSY), 64'd0);
  endtask

  task automatic check_common(input int n);
    chk("strobe_count", 64'(q_din.size()), 64'(n));
    chk("both_strobes", 64'(both_cnt), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    for (int i = 0; i < n && i < q_cyc.size() && i < acc_q.size(); i++)
      chk($sformatf("strobe_cycle%0d", i), 64'(q_cyc[i]), 64'(acc_q[i]));
  endtask

  initial begin
    bus.START = 0; bus.BCAST = 0; bus.FIRST_BUF = 0; bus.NUM_BUF = 0; bus.WORDS = 0;
    bus.S_DATA = 0; bus.S_VALID = 0;
    tick(); tick();
    chk("rst_d_en", 64'(bus.D_EN), 64'd0);
    chk("rst_all_en", 64'(bus.WBUF_ALL_EN), 64'd0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_done", 64'(bus.DONE), 64'd0);
    chk("rst_ready", 64'(bus.S_READY), 64'd0);
    chk("rst_addr", 64'(bus.WBUF_ADDR), 64'd0);
    RST = 1'b0;
    tick();

    // Single buffer fill
    clear_log();
    start_job(1'b0, 5'd3, 6'd1, 7'd4);
    feed(4, 32'hA0, 16'h0, 0);
    chk("t1_fin_strobe", 64'(bus.D_EN), 64'd1);
    chk("t1_fin_addr", 64'(bus.WBUF_ADDR), 64'd3);
    chk("t1_fin_ready", 64'(bus.S_READY), 64'd0);
    chk("t1_fin_done", 64'(bus.DONE), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(bus.DONE), 64'd1);
    chk("t1_done_busy", 64'(bus.BUSY), 64'd1);
    chk("t1_done_nostrobe", 64'(bus.D_EN), 64'd0);
    tick();
    chk("t1_idle_done", 64'(bus.DONE), 64'd0);
    chk("t1_idle_busy", 64'(bus.BUSY), 64'd0);
    check_common(4);
    for (int i = 0; i < 4 && i < q_din.size(); i++) begin
      chk("t1_din", 64'(q_din[i]), 64'd3);
      chk("t1_addr", 64'(q_addr[i]), 64'(i));
      chk("t1_data", 64'(q_data[i]), 64'(32'hA0 + i));
      chk("t1_all", 64'(q_all[i]), 64'd0);
    end

    // Buffer index wrap 30 -> 31 -> 0
    begin
      int exp_din[6] = '{30, 30, 31, 31, 0, 0};
      clear_log();
      start_job(1'b0, 5'd30, 6'd3, 7'd2);
      feed(6, 32'h10, 16'h0, 0);
      wait_idle();
      check_common(6);
      for (int i = 0; i < 6 && i < q_din.size(); i++) begin
        chk("t2_din", 64'(q_din[i]), 64'(exp_din[i]));
        chk("t2_addr", 64'(q_addr[i]), 64'(i % 2));
      end
    end

    // Broadcast: NUM_BUF ignored
    clear_log();
    start_job(1'b1, 5'd7, 6'd5, 7'd3);
    feed(3, 32'h20, 16'h0, 0);
    wait_idle();
    check_common(3);
    for (int i = 0; i < 3 && i < q_din.size(); i++) begin
      chk("t3_all", 64'(q_all[i]), 64'd1);
      chk("t3_din", 64'(q_din[i]), 64'd0);
      chk("t3_addr", 64'(q_addr[i]), 64'(i));
      chk("t3_data", 64'(q_data[i]), 64'(32'h20 + i));
    end

    // Valid gaps 1,0,0,1,1,0,1 plus an ignored mid-job START
    begin
      int exp_din[4] = '{5, 5, 6, 6};
      clear_log();
      start_job(1'b0, 5'd5, 6'd2, 7'd2);
      bus.START = 1'b1; bus.FIRST_BUF = 5'd9;
      tick();
      bus.START = 1'b0;
      chk("t4_still_ready", 64'(bus.S_READY), 64'd1);
      feed(4, 32'h30, 16'b1011001, 7);
      wait_idle();
      check_common(4);
      for (int i = 0; i < 4 && i < q_din.size(); i++) begin
        chk("t4_din", 64'(q_din[i]), 64'(exp_din[i]));
        chk("t4_addr", 64'(q_addr[i]), 64'(i % 2));
        chk("t4_data", 64'(q_data[i]), 64'(32'h30 + i));
      end
    end

    // Zero-length job
    clear_log();
    start_job(1'b0, 5'd0, 6'd4, 7'd0);
    chk("t5_zero_done", 64'(bus.DONE), 64'd1);
    chk("t5_zero_ready", 64'(bus.S_READY), 64'd0);
    tick();
    chk("t5_zero_idle", 64'(bus.BUSY), 64'd0);
    chk("t5_zero_strobes", 64'(q_din.size()), 64'd0);
    chk("t5_zero_rdy_seen", 64'(rdy_seen), 64'd0);
    chk("t5_zero_done_cnt", 64'(done_cnt), 64'd1);

    // NUM_BUF clamp 40 -> 32
    clear_log();
    start_job(1'b0, 5'd0, 6'd40, 7'd1);
    feed(32, 32'h100, 16'h0, 0);
    wait_idle();
    check_common(32);
    for (int i = 0; i < 32 && i < q_din.size(); i++)
      chk("t5_clamp_din", 64'(q_din[i]), 64'(i));

    // WORDS clamp 100 -> 64 in broadcast
    clear_log();
    start_job(1'b1, 5'd0, 6'd0, 7'd100);
    feed(64, 32'h200, 16'h0, 0);
    wait_idle();
    check_common(64);
    if (q_addr.size() == 64) chk("t5_words_last_addr", 64'(q_addr[63]), 64'd63);

    // Reset after 3 of 8 beats
    clear_log();
    start_job(1'b0, 5'd2, 6'd2, 7'd4);
    feed(3, 32'h50, 16'h0, 0);
    chk("t6_pre_rst_strobe", 64'(bus.D_EN), 64'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_rst_d_en", 64'(bus.D_EN), 64'd0);
    chk("t6_rst_all_en", 64'(bus.WBUF_ALL_EN), 64'd0);
    chk("t6_rst_din", 64'(bus.D_IN), 64'd0);
    chk("t6_rst_addr", 64'(bus.WBUF_ADDR), 64'd0);
    chk("t6_rst_data", 64'(bus.WBUF_DATA), 64'd0);
    chk("t6_rst_busy", 64'(bus.BUSY), 64'd0);
    chk("t6_rst_ready", 64'(bus.S_READY), 64'd0);
    tick(); tick(); tick();
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    clear_log();
    start_job(1'b0, 5'd1, 6'd1, 7'd2);
    feed(2, 32'h60, 16'h0, 0);
    wait_idle();
    check_common(2);
    for (int i = 0; i < 2 && i < q_din.size(); i++) begin
      chk("t6_din", 64'(q_din[i]), 64'd1);
      chk("t6_addr", 64'(q_addr[i]), 64'(i));
      chk("t6_data", 64'(q_data[i]), 64'(32'h60 + i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
